uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART_TX_CTRL transmitter between NUM_REQ byte sources, such as the button-string sender and the RX echo path. It sits between the requesters and UART_TX_CTRL's send/data/ready interface. It sequences each byte through a single send pulse and waits for the transmitter to return ready. An optional packet lock keeps a multi-byte string from being interleaved with other sources.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART TX arbiter.
// slave is the arbiter's view. master is the environment's view: the byte sources plus
// the ready line from UART_TX_CTRL.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 8
) ();
    logic [NUM_REQ-1:0]        REQ;
    logic [NUM_REQ-1:0]        LAST;
    logic [NUM_REQ*DATA_W-1:0] DATA;
    logic [NUM_REQ-1:0]        ACK;
    logic [NUM_REQ-1:0]        GRANT;
    logic                      BUSY;
    logic                      LOCKED;
    logic                      TX_SEND;
    logic [DATA_W-1:0]         TX_DATA;
    logic                      TX_READY;

    modport master (
        output REQ, LAST, DATA, TX_READY,
        input  ACK, GRANT, BUSY, LOCKED, TX_SEND, TX_DATA
    );

    modport slave (
        input  REQ, LAST, DATA, TX_READY,
        output ACK, GRANT, BUSY, LOCKED, TX_SEND, TX_DATA
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX_CTRL among NUM_REQ byte sources, with an
// optional packet lock so multi-byte strings are not interleaved.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned DATA_W       = 8,
    parameter logic [15:0] LOCK_TIMEOUT = 16'd50000
) (
    input logic              CLK,
    input logic              RST,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StHold,
        StWaitRdy
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [15:0]        lock_cnt_q;
    logic               locked_q;
    logic               busy_q;
    logic               tx_send_q;
    logic [DATA_W-1:0]  tx_data_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] grant_q;

    logic               owner_req;
    logic [NUM_REQ-1:0] cand;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   win_next;
    logic [NUM_REQ-1:0] win_onehot;
    logic [DATA_W-1:0]  win_data;
    logic               win_last;
    logic               lock_expire;

    // Candidate set and round-robin winner search starting at ptr_q.
    always_comb begin
        owner_req  = 1'b0;
        win_valid  = 1'b0;
        win_idx    = '0;
        win_next   = '0;
        win_onehot = '0;
        win_data   = '0;
        win_last   = 1'b0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (owner_q == IDX_W'(j)) begin
                owner_req = bus.REQ[j];
            end
        end
        cand = bus.REQ;
        if (locked_q) begin
            // While locked only the packet owner may be granted.
            for (int j = 0; j < int'(NUM_REQ); j++) begin
                if (owner_q != IDX_W'(j)) begin
                    cand[j] = 1'b0;
                end
            end
        end
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            for (int j = 0; j < int'(NUM_REQ); j++) begin
                if (!win_valid && cand[j] &&
                    ((int'(ptr_q) + k == j) || (int'(ptr_q) + k - int'(NUM_REQ) == j))) begin
                    win_valid     = 1'b1;
                    win_idx       = IDX_W'(j);
                    win_next      = (j == int'(NUM_REQ) - 1) ? '0 : IDX_W'(j + 1);
                    win_onehot[j] = 1'b1;
                    win_data      = bus.DATA[j*DATA_W +: DATA_W];
                    win_last      = bus.LAST[j];
                end
            end
        end
        lock_expire = (LOCK_TIMEOUT != 16'd0) && (lock_cnt_q == LOCK_TIMEOUT - 16'd1);
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            busy_q     <= 1'b0;
            tx_send_q  <= 1'b0;
            tx_data_q  <= '0;
            ack_q      <= '0;
            grant_q    <= '0;
        end else begin
            tx_send_q <= 1'b0;
            ack_q     <= '0;
            case (state_q)
                StIdle: begin
                    // No grant unless the transmitter is ready, so nothing collides with a
                    // byte still in flight (including one started before a reset).
                    if (bus.TX_READY && win_valid) begin
                        tx_data_q  <= win_data;
                        grant_q    <= win_onehot;
                        ack_q      <= win_onehot;
                        tx_send_q  <= 1'b1;
                        owner_q    <= win_idx;
                        ptr_q      <= win_next;
                        locked_q   <= ~win_last;
                        lock_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StIssue;
                    end else if (locked_q && !owner_req) begin
                        if (lock_expire) begin
                            locked_q   <= 1'b0;
                            lock_cnt_q <= '0;
                        end else begin
                            lock_cnt_q <= lock_cnt_q + 16'd1;
                        end
                    end else begin
                        lock_cnt_q <= '0;
                    end
                end
                StIssue: begin
                    state_q <= StHold;
                end
                StHold: begin
                    // UART_TX_CTRL needs a cycle to drop ready after send.
                    state_q <= StWaitRdy;
                end
                StWaitRdy: begin
                    if (bus.TX_READY) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.TX_SEND = tx_send_q;
    assign bus.TX_DATA = tx_data_q;
    assign bus.ACK     = ack_q;
    assign bus.GRANT   = grant_q;
    assign bus.BUSY    = busy_q;
    assign bus.LOCKED  = locked_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a model UART_TX_CTRL, per-requester byte
// agents and a scoreboard of expected sends in grant order.
module tb_uart_tx_arbiter;
    typedef struct packed {
        logic [1:0] ack;
        logic [7:0] data;
        logic       locked;
    } exp_t;

    logic CLK;
    logic RST;

    uart_tx_arbiter_if #(.NUM_REQ(2), .DATA_W(8)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (2),
        .DATA_W       (8),
        .LOCK_TIMEOUT (16'd10)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int cyc = 0;
    exp_t exp_q[$];
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int send_cyc_q[$];

    int tx_len  = 0;
    bit glitch  = 0;
    int mdl_cnt = 0;
    int mdl_gl  = 0;

    int busy_cnt = 0;
    int locked_cnt = 0;
    int locked_idle_cnt = 0;
    int inv_err = 0;
    bit prev_send = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int send_at(input int i);
        return (i < send_cyc_q.size()) ? send_cyc_q[i] : -1000;
    endfunction

    function automatic int gap(input int i);
        return send_at(i + 1) - send_at(i);
    endfunction

    task automatic expect_byte(input logic [1:0] ack, input logic [7:0] d, input logic lk);
        exp_t e;
        e.ack = ack;
        e.data = d;
        e.locked = lk;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic clear_stats();
        send_cyc_q.delete();
        busy_cnt = 0;
        locked_cnt = 0;
        locked_idle_cnt = 0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0 || bus.BUSY) &&
               n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
    endtask

    // Requester agents: hold REQ/DATA/LAST from the queue front until ACK.
    initial begin
        bus.REQ  = '0;
        bus.LAST = '0;
        bus.DATA = '0;
        forever begin
            @(negedge CLK);
            if (bus.ACK[0] && q0.size() > 0) void'(q0.pop_front());
            if (bus.ACK[1] && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                bus.REQ[0] = 1'b1;
                bus.LAST[0] = q0[0][8];
                bus.DATA[7:0] = q0[0][7:0];
            end else begin
                bus.REQ[0] = 1'b0;
            end
            if (q1.size() > 0) begin
                bus.REQ[1] = 1'b1;
                bus.LAST[1] = q1[0][8];
                bus.DATA[15:8] = q1[0][7:0];
            end else begin
                bus.REQ[1] = 1'b0;
            end
        end
    end

    // Model UART_TX_CTRL: ready low for tx_len cycles after send; with glitch set, ready
    // stays high through HOLD before dropping.
    initial begin
        bus.TX_READY = 1'b1;
        forever begin
            @(negedge CLK);
            if (bus.TX_SEND) begin
                mdl_cnt = tx_len;
                mdl_gl = glitch ? 2 : 0;
            end else if (mdl_gl > 0) begin
                mdl_gl--;
            end else if (mdl_cnt > 0) begin
                mdl_cnt--;
            end
            bus.TX_READY = (mdl_gl != 0) || (mdl_cnt == 0);
        end
    end

    // Monitor: scoreboard pop on each send plus cycle statistics.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.BUSY) busy_cnt++;
            if (bus.LOCKED) locked_cnt++;
            if (bus.LOCKED && !bus.BUSY) locked_idle_cnt++;
            if (bus.BUSY && bus.GRANT == 2'b00) inv_err++;
            if (bus.TX_SEND && prev_send) inv_err++;
            prev_send = bus.TX_SEND;
            if (bus.TX_SEND || bus.ACK != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_send", 32'({bus.ACK, bus.TX_SEND}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", 32'(bus.TX_DATA), 32'(e.data));
                    check("send_ack", 32'({bus.TX_SEND, bus.ACK}), 32'({1'b1, e.ack}));
                    check("locked_at_send", 32'(bus.LOCKED), 32'(e.locked));
                    send_cyc_q.push_back(cyc);
                end
            end
        end
    end

    initial begin
        int enq_cyc;
        int rst_cyc;
        int n;
        RST = 1'b1;

        // Reset values.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_tx_send", 32'(bus.TX_SEND), 32'd0);
        check("rst_tx_data", 32'(bus.TX_DATA), 32'd0);
        check("rst_ack", 32'(bus.ACK), 32'd0);
        check("rst_grant", 32'(bus.GRANT), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_locked", 32'(bus.LOCKED), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Single byte with a slow transmitter.
        @(posedge CLK);
        #1;
        tx_len = 100;
        clear_stats();
        enq_cyc = cyc;
        expect_byte(2'b01, 8'h41, 1'b0);
        q0.push_back({1'b1, 8'h41});
        wait_drain("single", 300);
        check("single_latency", 32'(send_at(0) - enq_cyc), 32'd1);
        check("single_busy_cycles", 32'(busy_cnt), 32'd101);
        check("single_locked_cycles", 32'(locked_cnt), 32'd0);

        // Contention with an instantly ready transmitter.
        do_reset();
        tx_len = 0;
        clear_stats();
        expect_byte(2'b01, 8'hA0, 1'b0);
        expect_byte(2'b10, 8'hB0, 1'b0);
        expect_byte(2'b01, 8'hA1, 1'b0);
        expect_byte(2'b10, 8'hB1, 1'b0);
        q0.push_back({1'b1, 8'hA0});
        q0.push_back({1'b1, 8'hA1});
        q1.push_back({1'b1, 8'hB0});
        q1.push_back({1'b1, 8'hB1});
        wait_drain("contention", 100);
        for (int i = 0; i < 3; i++) check("b2b_gap", 32'(gap(i)), 32'd4);

        // Packet lock: "ARTY" from requester 0 is not interleaved with requester 1.
        do_reset();
        tx_len = 3;
        clear_stats();
        expect_byte(2'b01, 8'h41, 1'b1);
        expect_byte(2'b01, 8'h52, 1'b1);
        expect_byte(2'b01, 8'h54, 1'b1);
        expect_byte(2'b01, 8'h59, 1'b0);
        expect_byte(2'b10, 8'h5A, 1'b0);
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b0, 8'h52});
        q0.push_back({1'b0, 8'h54});
        q0.push_back({1'b1, 8'h59});
        q1.push_back({1'b1, 8'h5A});
        wait_drain("lock", 200);
        check("lock_locked_cycles", 32'(locked_cnt), 32'd15);
        check("lock_period", 32'(gap(0)), 32'd5);

        // Lock timeout: owner drops REQ after an unterminated packet.
        do_reset();
        tx_len = 3;
        clear_stats();
        expect_byte(2'b01, 8'h77, 1'b1);
        expect_byte(2'b10, 8'h88, 1'b0);
        q0.push_back({1'b0, 8'h77});
        q1.push_back({1'b1, 8'h88});
        wait_drain("timeout", 200);
        check("timeout_locked_idle", 32'(locked_idle_cnt), 32'd10);
        check("timeout_gap", 32'(gap(0)), 32'd15);
        check("timeout_unlocked", 32'(bus.LOCKED), 32'd0);

        // Ready stays high through HOLD; the next send must wait for the real ready.
        do_reset();
        tx_len = 5;
        glitch = 1'b1;
        clear_stats();
        expect_byte(2'b01, 8'h61, 1'b0);
        expect_byte(2'b01, 8'h62, 1'b0);
        q0.push_back({1'b1, 8'h61});
        q0.push_back({1'b1, 8'h62});
        wait_drain("glitch", 200);
        check("glitch_gap", 32'(gap(0)), 32'd9);
        glitch = 1'b0;

        // Reset while a byte is in flight; ptr returns to 0 so requester 0 wins.
        do_reset();
        tx_len = 200;
        clear_stats();
        expect_byte(2'b01, 8'hC1, 1'b0);
        q0.push_back({1'b1, 8'hC1});
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("midrst_first_sent", 32'(exp_q.size()), 32'd0);
        expect_byte(2'b01, 8'hC2, 1'b0);
        expect_byte(2'b10, 8'hC3, 1'b0);
        q0.push_back({1'b1, 8'hC2});
        q1.push_back({1'b1, 8'hC3});
        repeat (10) @(posedge CLK);
        #1;
        check("midrst_busy_before", 32'(bus.BUSY), 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        rst_cyc = cyc;
        mdl_cnt = 50;
        mdl_gl = 0;
        tx_len = 2;
        send_cyc_q.delete();
        @(negedge CLK);
        check("midrst_tx_send", 32'(bus.TX_SEND), 32'd0);
        check("midrst_ack", 32'(bus.ACK), 32'd0);
        check("midrst_grant", 32'(bus.GRANT), 32'd0);
        check("midrst_busy", 32'(bus.BUSY), 32'd0);
        check("midrst_tx_data", 32'(bus.TX_DATA), 32'd0);
        wait_drain("midrst", 300);
        check("midrst_sends", 32'(send_cyc_q.size()), 32'd2);
        check("midrst_first_send_delay", 32'(send_at(0) - rst_cyc), 32'd50);

        check("invariants", 32'(inv_err), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
